// File: rtl/shift_issue_pkg.sv
// -----------------------------------------------------------------------------
// shift_issue_pkg
// Shared definitions for the shift issue buffer and the Shifter it feeds:
//   - MIPS R-type funct codes for the six shift instructions
//   - Shifter shiftop encoding (same constants the Shifter itself uses)
//   - the translated entry record held by the skid buffer
// -----------------------------------------------------------------------------
package shift_issue_pkg;

  // Operand width of the Shifter datapath. The issue block's DATA_W must match.
  localparam int SHIFT_DATA_W = 32;

  // R-type funct codes
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  // Shifter shiftop encoding; 2'b11 is never produced.
  typedef enum logic [1:0] {
    SHOP_SRL = 2'b00,
    SHOP_SRA = 2'b01,
    SHOP_SLL = 2'b10
  } shop_e;

  // One translated instruction, ready to drive the Shifter.
  typedef struct packed {
    logic [SHIFT_DATA_W-1:0] data;
    shop_e                   op;
    logic [4:0]              amt;
    logic [4:0]              rd;
  } shift_entry_t;

endpackage

// File: rtl/shift_decode.sv
// -----------------------------------------------------------------------------
// shift_decode
// Purely combinational translation of a shift instruction's funct field into
// the Shifter's shiftop and shift amount.
//   funct  : R-type funct field
//   shamt  : immediate shift amount (sll/srl/sra)
//   rs_amt : rs[4:0], shift amount for the variable forms (sllv/srlv/srav)
//   op     : Shifter shiftop
//   amt    : Shifter shiftamt
//   legal  : 1 when funct is one of the six shift instructions
// -----------------------------------------------------------------------------
module shift_decode
  import shift_issue_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  input  logic [4:0] rs_amt,
  output shop_e      op,
  output logic [4:0] amt,
  output logic       legal
);

  // NOTE: every output gets a default at the top of the block so no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    op    = SHOP_SRL;
    amt   = shamt;
    legal = 1'b1;
    case (funct)
      FUNCT_SLL:  op = SHOP_SLL;
      FUNCT_SRL:  op = SHOP_SRL;
      FUNCT_SRA:  op = SHOP_SRA;
      FUNCT_SLLV: begin
        op  = SHOP_SLL;
        amt = rs_amt;
      end
      FUNCT_SRLV: begin
        op  = SHOP_SRL;
        amt = rs_amt;
      end
      FUNCT_SRAV: begin
        op  = SHOP_SRA;
        amt = rs_amt;
      end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_issue.sv
// -----------------------------------------------------------------------------
// shift_issue
// Execute-stage issue buffer in front of the combinational Shifter. Accepts
// decoded R-type shift instructions, translates them to Shifter controls and
// holds them in a 2-entry skid buffer (main M drives the outputs, skid S
// catches one instruction while M is stalled).
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : upstream handshake; in_ready is registered (!S.valid)
//   in_funct, in_shamt, in_rs, in_rt, in_rd : instruction fields
//   flush             : synchronous flush of both entries
//   out_valid/out_ready : downstream handshake
//   sh_in, sh_op, sh_amt, sh_rd : Shifter operand, controls and destination
//   illegal_cnt       : saturating count of rejected funct codes
// -----------------------------------------------------------------------------
module shift_issue
  import shift_issue_pkg::*;
#(
  parameter int DATA_W = SHIFT_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_shamt,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [4:0]        in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sh_in,
  output logic [1:0]        sh_op,
  output logic [4:0]        sh_amt,
  output logic [4:0]        sh_rd,
  output logic [CNT_W-1:0]  illegal_cnt
);

  if (DATA_W != SHIFT_DATA_W) begin : g_width_check
    $error("shift_issue: DATA_W must equal the Shifter width SHIFT_DATA_W");
  end

  // Only the low five bits of rs carry a shift amount.
  logic unused_rs_hi;
  assign unused_rs_hi = ^in_rs[DATA_W-1:5];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  shop_e        dec_op;
  logic [4:0]   dec_amt;
  logic         dec_legal;
  shift_entry_t dec_entry;

  shift_decode u_decode (
    .funct  (in_funct),
    .shamt  (in_shamt),
    .rs_amt (in_rs[4:0]),
    .op     (dec_op),
    .amt    (dec_amt),
    .legal  (dec_legal)
  );

  always_comb begin
    dec_entry.data = in_rt;
    dec_entry.op   = dec_op;
    dec_entry.amt  = dec_amt;
    dec_entry.rd   = in_rd;
  end

  // ---------------------------------------------------------------------------
  // Skid buffer state
  // ---------------------------------------------------------------------------
  shift_entry_t     m_q, m_n, s_q, s_n;
  logic             m_valid_q, m_valid_n;
  logic             s_valid_q, s_valid_n;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic accept, consume, push;

  assign accept  = in_valid & in_ready_q;
  assign consume = m_valid_q & out_ready;
  assign push    = accept & dec_legal;

  always_comb begin
    m_n       = m_q;
    s_n       = s_q;
    m_valid_n = m_valid_q;
    s_valid_n = s_valid_q;
    cnt_n     = cnt_q;
    if (flush) begin
      // Entry data is left as-is; only the valid bits are dropped, and any
      // same-cycle input (legal or not) is ignored.
      m_valid_n = 1'b0;
      s_valid_n = 1'b0;
    end else begin
      if (consume) begin
        if (s_valid_q) begin
          // in_ready was low, so nothing new can arrive this cycle.
          m_n       = s_q;
          s_valid_n = 1'b0;
        end else if (push) begin
          m_n = dec_entry;
        end else begin
          m_valid_n = 1'b0;
        end
      end else if (push) begin
        if (m_valid_q) begin
          s_n       = dec_entry;
          s_valid_n = 1'b1;
        end else begin
          m_n       = dec_entry;
          m_valid_n = 1'b1;
        end
      end
      if (accept && !dec_legal && (cnt_q != '1)) begin
        cnt_n = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  // NOTE: both entries (data included) are reset because the outputs must read
  // zero during reset; this is two registers, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q        <= '0;
      s_q        <= '0;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      m_q        <= m_n;
      s_q        <= s_n;
      m_valid_q  <= m_valid_n;
      s_valid_q  <= s_valid_n;
      in_ready_q <= !s_valid_n;
      cnt_q      <= cnt_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight from registers
  // ---------------------------------------------------------------------------
  assign in_ready    = in_ready_q;
  assign out_valid   = m_valid_q;
  assign sh_in       = m_q.data;
  assign sh_op       = m_q.op;
  assign sh_amt      = m_q.amt;
  assign sh_rd       = m_q.rd;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_shift_issue.sv
// -----------------------------------------------------------------------------
// tb_shift_issue
// Self-checking bench for shift_issue: a decode table, directed multi-cycle
// sequences (backpressure, flush, async reset, saturation) and a randomized
// run compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_shift_issue;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_funct;
  logic [4:0]    in_shamt;
  logic [DW-1:0] in_rs;
  logic [DW-1:0] in_rt;
  logic [4:0]    in_rd;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sh_in;
  logic [1:0]    sh_op;
  logic [4:0]    sh_amt;
  logic [4:0]    sh_rd;
  logic [CW-1:0] illegal_cnt;

  shift_issue #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_shamt    (in_shamt),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sh_in       (sh_in),
    .sh_op       (sh_op),
    .sh_amt      (sh_amt),
    .sh_rd       (sh_rd),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural Shifter, used to confirm the operands produce the right result.
  function automatic logic [DW-1:0] shifter(input logic [DW-1:0] d, input logic [1:0] op,
                                            input logic [4:0] amt);
    case (op)
      2'b00:   return d >> amt;
      2'b01:   return DW'($signed(d) >>> amt);
      2'b10:   return d << amt;
      default: return 'x;
    endcase
  endfunction

  // Reference decode straight from the instruction table.
  function automatic void ref_decode(input logic [5:0] f, input logic [4:0] shamt,
                                     input logic [DW-1:0] rs, output bit legal,
                                     output logic [1:0] op, output logic [4:0] amt);
    legal = 1'b1;
    op    = 2'b00;
    amt   = shamt;
    case (f)
      6'h00: op = 2'b10;
      6'h02: op = 2'b00;
      6'h03: op = 2'b01;
      6'h04: begin op = 2'b10; amt = rs[4:0]; end
      6'h06: begin op = 2'b00; amt = rs[4:0]; end
      6'h07: begin op = 2'b01; amt = rs[4:0]; end
      default: legal = 1'b0;
    endcase
  endfunction

  // Present one instruction for a single edge (caller guarantees in_ready=1).
  task automatic drive(input logic [5:0] f, input logic [4:0] sa, input logic [DW-1:0] rs,
                       input logic [DW-1:0] rt, input logic [4:0] rd);
    in_valid = 1'b1;
    in_funct = f;
    in_shamt = sa;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [5:0]    funct;
    logic [4:0]    shamt;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [4:0]    rd;
    bit            legal;
    logic [1:0]    op;
    logic [4:0]    amt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    op;
    logic [4:0]    amt;
    logic [4:0]    rd;
  } exp_entry_t;

  initial begin
    vec_t       vecs[11];
    exp_entry_t q[$];
    exp_entry_t e;
    logic [5:0] legal_list[6];
    int         exp_cnt;
    int         mcnt;
    bit         hold;
    bit         acc;
    bit         lg;
    bit         any_valid;
    int         k;

    vecs[0]  = '{6'h00, 5'd7,  32'h0000_0000, 32'h1234_5678, 5'd1,  1'b1, 2'b10, 5'd7};
    vecs[1]  = '{6'h02, 5'd31, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 5'd2,  1'b1, 2'b00, 5'd31};
    vecs[2]  = '{6'h03, 5'd0,  32'h0000_001F, 32'h8000_0001, 5'd3,  1'b1, 2'b01, 5'd0};
    vecs[3]  = '{6'h04, 5'd9,  32'hFFFF_FFE5, 32'h0000_00FF, 5'd4,  1'b1, 2'b10, 5'd5};
    vecs[4]  = '{6'h06, 5'd2,  32'h0000_0040, 32'hCAFE_F00D, 5'd5,  1'b1, 2'b00, 5'd0};
    vecs[5]  = '{6'h07, 5'd0,  32'h0000_001F, 32'h8000_0000, 5'd31, 1'b1, 2'b01, 5'd31};
    vecs[6]  = '{6'h01, 5'd3,  32'h0000_0001, 32'h0000_0001, 5'd6,  1'b0, 2'b00, 5'd0};
    vecs[7]  = '{6'h05, 5'd3,  32'h0000_0001, 32'h0000_0001, 5'd7,  1'b0, 2'b00, 5'd0};
    vecs[8]  = '{6'h20, 5'd3,  32'h0000_0001, 32'h0000_0001, 5'd8,  1'b0, 2'b00, 5'd0};
    vecs[9]  = '{6'h3F, 5'd3,  32'h0000_0001, 32'h0000_0001, 5'd9,  1'b0, 2'b00, 5'd0};
    vecs[10] = '{6'h08, 5'd3,  32'h0000_0001, 32'h0000_0001, 5'd10, 1'b0, 2'b00, 5'd0};
    legal_list = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_funct  = '0;
    in_shamt  = '0;
    in_rs     = '0;
    in_rt     = '0;
    in_rd     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = 0;

    // ---- reset values and a single sra ----
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sh_in", sh_in, 0);
    check("rst_sh_op", sh_op, 0);
    check("rst_sh_amt", sh_amt, 0);
    check("rst_sh_rd", sh_rd, 0);
    check("rst_cnt", illegal_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    drive(6'h03, 5'd4, 32'h0, 32'h8000_0000, 5'd9);
    check("sra_valid", out_valid, 1);
    check("sra_op", sh_op, 2'b01);
    check("sra_amt", sh_amt, 5'd4);
    check("sra_in", sh_in, 32'h8000_0000);
    check("sra_rd", sh_rd, 5'd9);
    check("sra_result", shifter(sh_in, sh_op, sh_amt), 32'hF800_0000);

    // ---- variable shift ----
    drive(6'h04, 5'd0, 32'h0000_0023, 32'h0000_0001, 5'd12);
    check("sllv_op", sh_op, 2'b10);
    check("sllv_amt", sh_amt, 5'd3);
    check("sllv_result", shifter(sh_in, sh_op, sh_amt), 32'h0000_0008);

    // ---- decode table ----
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].funct, vecs[i].shamt, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      if (!vecs[i].legal) exp_cnt++;
      check($sformatf("tbl%0d_valid", i), out_valid, vecs[i].legal);
      check($sformatf("tbl%0d_cnt", i), illegal_cnt, exp_cnt);
      if (vecs[i].legal) begin
        check($sformatf("tbl%0d_op", i), sh_op, vecs[i].op);
        check($sformatf("tbl%0d_amt", i), sh_amt, vecs[i].amt);
        check($sformatf("tbl%0d_in", i), sh_in, vecs[i].rt);
        check($sformatf("tbl%0d_rd", i), sh_rd, vecs[i].rd);
      end
    end
    @(negedge clk);
    check("drained", out_valid, 0);

    // ---- backpressure ----
    out_ready = 1'b0;
    drive(6'h02, 5'd1, 32'h0, 32'h0000_00F0, 5'd1);
    check("bp1_valid", out_valid, 1);
    check("bp1_in_ready", in_ready, 1);
    drive(6'h00, 5'd2, 32'h0, 32'h0000_000F, 5'd2);
    check("bp2_in_ready", in_ready, 0);
    check("bp2_rd_held", sh_rd, 5'd1);
    in_valid = 1'b1;
    in_funct = 6'h02;
    in_shamt = 5'd3;
    in_rt    = 32'h0000_0100;
    in_rd    = 5'd3;
    @(negedge clk);
    check("bp3_in_ready", in_ready, 0);
    check("bp3_rd_held", sh_rd, 5'd1);
    check("bp3_op_held", sh_op, 2'b00);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp4_rd", sh_rd, 5'd2);
    check("bp4_op", sh_op, 2'b10);
    check("bp4_amt", sh_amt, 5'd2);
    check("bp4_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp5_rd", sh_rd, 5'd3);
    check("bp5_valid", out_valid, 1);
    @(negedge clk);
    check("bp6_valid", out_valid, 0);

    // ---- flush ----
    out_ready = 1'b0;
    drive(6'h00, 5'd1, 32'h0, 32'h1, 5'd10);
    drive(6'h00, 5'd1, 32'h0, 32'h2, 5'd11);
    check("fl_full", in_ready, 0);
    in_valid = 1'b1;
    in_funct = 6'h03;
    in_rd    = 5'd12;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_funct = 6'h02;
    in_rd    = 5'd13;
    flush    = 1'b1;
    @(negedge clk);
    in_funct = 6'h20;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_concurrent_valid", out_valid, 0);
    check("fl_cnt_kept", illegal_cnt, exp_cnt);
    out_ready = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      any_valid |= out_valid;
    end
    check("fl_nothing_emerges", any_valid, 0);

    // ---- asynchronous reset with M valid ----
    out_ready = 1'b0;
    drive(6'h00, 5'd5, 32'h0, 32'h0000_AAAA, 5'd7);
    check("ar_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_sh_in", sh_in, 0);
    check("ar_sh_op", sh_op, 0);
    check("ar_sh_amt", sh_amt, 0);
    check("ar_sh_rd", sh_rd, 0);
    check("ar_cnt", illegal_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_in_ready", in_ready, 1);
    out_ready = 1'b1;
    drive(6'h02, 5'd2, 32'h0, 32'h0000_0100, 5'd4);
    check("ar_new_valid", out_valid, 1);
    check("ar_new_rd", sh_rd, 5'd4);
    check("ar_new_result", shifter(sh_in, sh_op, sh_amt), 32'h0000_0040);

    // ---- randomized run against the queue model ----
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mcnt = 0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      check("rnd_in_ready", in_ready, q.size() < 2);
      check("rnd_out_valid", out_valid, q.size() != 0);
      check("rnd_cnt", illegal_cnt, mcnt);
      if (q.size() != 0) begin
        check("rnd_sh_in", sh_in, q[0].data);
        check("rnd_sh_op", sh_op, q[0].op);
        check("rnd_sh_amt", sh_amt, q[0].amt);
        check("rnd_sh_rd", sh_rd, q[0].rd);
      end
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        k = $urandom_range(0, 7);
        in_funct = (k < 6) ? legal_list[k] : 6'($urandom);
        in_shamt = 5'($urandom);
        in_rs    = $urandom;
        in_rt    = $urandom;
        in_rd    = 5'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      acc = in_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
        hold = 1'b0;
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) begin
          ref_decode(in_funct, in_shamt, in_rs, lg, e.op, e.amt);
          e.data = in_rt;
          e.rd   = in_rd;
          if (lg) q.push_back(e);
          else if (mcnt < 255) mcnt++;
        end
        hold = in_valid && !acc;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush    = 1'b0;

    // ---- illegal saturation ----
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_valid  = 1'b1;
    in_funct  = 6'h20;
    any_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      any_valid |= out_valid;
    end
    check("sat_no_valid", any_valid, 0);
    check("sat_cnt", illegal_cnt, 255);
    repeat (3) @(negedge clk);
    check("sat_cnt_hold", illegal_cnt, 255);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_issue.md
Name: shift_issue

Overview:
- Execute-stage issue buffer that sits directly upstream of the combinational Shifter (in, shiftop, shiftamt -> result).
- Accepts decoded MIPS R-type shift instructions (funct, shamt, rs/rt operands, destination rd) over a valid/ready handshake.
- Translates each instruction into the Shifter's operand, shiftop and shiftamt.
- Holds the translated operands in a 2-entry skid buffer, so backpressure from the execute/writeback side never drops an instruction.

Parameters:
- DATA_W, 32, operand width; must equal the Shifter data width.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  block can accept this cycle.
- in_funct  input  6  R-type funct field.
- in_shamt  input  5  immediate shift amount field.
- in_rs  input  DATA_W  rs register value; supplies the amount for variable shifts.
- in_rt  input  DATA_W  rt register value; this is the value that gets shifted.
- in_rd  input  5  destination register.
- flush  input  1  synchronous pipeline flush.
- out_valid  output  1  translated entry available.
- out_ready  input  1  downstream consumes this cycle.
- sh_in  output  DATA_W  drives Shifter in.
- sh_op  output  2  drives Shifter shiftop.
- sh_amt  output  5  drives Shifter shiftamt.
- sh_rd  output  5  destination, travels alongside the result.
- illegal_cnt  output  CNT_W  count of rejected funct codes.

Behaviour:
- Reset (rst_n low, asynchronous): both buffer entries invalid.
  - out_valid=0, sh_in=0, sh_op=2'b00, sh_amt=0, sh_rd=0, illegal_cnt=0.
  - in_ready is 1 from the first edge after rst_n deasserts.
- Reset mid-transfer discards all held entries.
- Decode (combinational on input fields), shiftop encoding: 00 logical right, 01 arithmetic right, 10 logical left.
  - funct 0x00 sll -> op 10, amt in_shamt.
  - funct 0x02 srl -> op 00, amt in_shamt.
  - funct 0x03 sra -> op 01, amt in_shamt.
  - funct 0x04 sllv -> op 10, amt in_rs[4:0].
  - funct 0x06 srlv -> op 00, amt in_rs[4:0].
  - funct 0x07 srav -> op 01, amt in_rs[4:0].
  - In all legal cases sh_in = in_rt.
  - Any other funct is illegal: the block accepts it (consumes the handshake), does not enqueue it, and increments illegal_cnt.
  - op 11 is never emitted.
- Handshake:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - in_valid must hold its fields stable until accepted; out_valid holds until consumed.
- Buffer: main register M (drives outputs) and skid register S.
  - in_ready = !S.valid (registered, no combinational path from out_ready).
  - Accept with M empty, or M being consumed and S empty: write M. Latency 1 cycle from accept to out_valid.
  - Accept while M is held (out_ready=0): write S.
  - M consumed while S valid: M<=S, S invalid. An accept in that cycle is impossible, since in_ready=0.
  - Simultaneous accept and consume with S empty: M replaced by the new entry; out_valid stays 1.
  - Ordering: strictly FIFO, 2 entries max.
- Flush (synchronous, highest priority below reset):
  - M and S invalidated at the edge; any same-cycle input transfer is discarded and illegal_cnt is not incremented by it.
  - illegal_cnt is not cleared.
  - Next cycle: out_valid=0, in_ready=1.
- illegal_cnt saturates at 2^CNT_W-1 and is never wrapped.
- Output data fields are don't-care when out_valid=0 but must hold their last value; they are not cleared on consume.

Decomposition:
- Shared package:
  - funct constants FUNCT_SLL/SRL/SRA/SLLV/SRLV/SRAV.
  - shiftop constants SHOP_SRL=2'b00, SHOP_SRA=2'b01, SHOP_SLL=2'b10.
  - Entry record type {data, op, amt, rd}.
  - The Shifter uses the same shiftop constants.
- One sub-module, shift_decode: combinational funct/shamt/rs -> {op, amt, legal}.
  - Lets the decode table be tested standalone.
- The skid buffer stays in shift_issue.

Test Plan:
- Reset and single instruction: pulse rst_n low, then issue sra funct=0x03, shamt=4, rt=0x80000000, rd=9, out_ready=1.
  - Next cycle: out_valid=1, sh_op=01, sh_amt=4, sh_in=0x80000000, sh_rd=9.
  - Shifter result 0xF8000000.
- Variable shift: sllv funct=0x04, rs=0x00000023, rt=0x00000001.
  - sh_op=10, sh_amt=3 (rs[4:0]); Shifter result 0x00000008.
- Backpressure: out_ready=0, issue srl(amt 1), sll(amt 2), then a third.
  - in_ready=0 after the second accept.
  - Raise out_ready: outputs srl then sll, in order; in_ready returns to 1 the cycle after the first consume.
- Illegal and saturation: issue funct=0x20 repeatedly, 300 times.
  - out_valid stays 0; illegal_cnt reads 255 and holds.
- Flush: with both entries full and in_valid=1, assert flush for one cycle.
  - Next cycle: out_valid=0, in_ready=1; neither held entry nor the concurrent input ever appears at the output.
- Async reset mid-operation: drop rst_n between clock edges with M valid.
  - Outputs zero immediately, without waiting for a clock edge; after release the first new instruction appears with latency 1.
